// File: rtl/clk_burst_ctrl.sv
// Bench clock sequencer: holds a DUT reset, then emits a divided clock
// for a fixed number of rising edges or until stopped; always ends low.
module clk_burst_ctrl #(
  parameter int G_CNT_WIDTH  = 16,
  parameter int G_DIV_WIDTH  = 8,
  parameter int G_RST_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [G_CNT_WIDTH-1:0] burst_len_i,
  input  logic [G_DIV_WIDTH-1:0] half_period_i,
  output logic                   clk_gen_o,
  output logic                   rise_o,
  output logic                   dut_rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [G_CNT_WIDTH-1:0] cycles_o
);

  localparam int RW = $clog2(G_RST_CYCLES + 1);
  localparam logic [RW-1:0] C_RST_LAST = RW'(G_RST_CYCLES - 1);
  localparam logic [RW-1:0] C_RST_ONE = RW'(1);
  localparam logic [G_CNT_WIDTH-1:0] C_CNT_ONE = G_CNT_WIDTH'(1);
  localparam logic [G_DIV_WIDTH-1:0] C_DIV_ONE = G_DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_clk_gen;
  logic                   r_rise;
  logic                   r_dut_rst;
  logic                   r_done;
  logic [G_CNT_WIDTH-1:0] r_cycles;
  logic [RW-1:0]          r_rst_cnt;
  logic [G_DIV_WIDTH-1:0] r_div_cnt;
  logic [G_CNT_WIDTH-1:0] r_burst_len;
  logic [G_DIV_WIDTH-1:0] r_hp;
  logic                   r_stop_pend;

  state_t                 w_state_nxt;
  logic                   w_clk_nxt;
  logic                   w_rise_nxt;
  logic                   w_dut_rst_nxt;
  logic                   w_done_nxt;
  logic [G_CNT_WIDTH-1:0] w_cycles_nxt;
  logic [RW-1:0]          w_rst_cnt_nxt;
  logic [G_DIV_WIDTH-1:0] w_div_nxt;
  logic [G_CNT_WIDTH-1:0] w_burst_nxt;
  logic [G_DIV_WIDTH-1:0] w_hp_nxt;
  logic                   w_pend_nxt;
  logic                   w_toggle;
  logic                   w_burst_end;

  assign w_toggle    = (r_div_cnt == (r_hp - C_DIV_ONE));
  assign w_burst_end = (r_burst_len != '0) && (r_cycles == r_burst_len);

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_nxt     = r_clk_gen;
    w_rise_nxt    = 1'b0;
    w_dut_rst_nxt = r_dut_rst;
    w_done_nxt    = 1'b0;
    w_cycles_nxt  = r_cycles;
    w_rst_cnt_nxt = r_rst_cnt;
    w_div_nxt     = r_div_cnt;
    w_burst_nxt   = r_burst_len;
    w_hp_nxt      = r_hp;
    w_pend_nxt    = r_stop_pend;
    unique case (r_state)
      S_IDLE: begin
        w_clk_nxt  = 1'b0;
        w_pend_nxt = 1'b0;
        if (start_i && (half_period_i != '0)) begin
          w_state_nxt   = S_RESET;
          w_burst_nxt   = burst_len_i;
          w_hp_nxt      = half_period_i;
          w_cycles_nxt  = '0;
          w_dut_rst_nxt = 1'b1;
          w_rst_cnt_nxt = '0;
        end
      end
      S_RESET: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_rst_cnt == C_RST_LAST) begin
          w_state_nxt   = S_RUN;
          w_dut_rst_nxt = 1'b0;
          w_div_nxt     = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + C_RST_ONE;
        end
      end
      S_RUN: begin
        if (!r_clk_gen && stop_i) begin
          // low phase: stop immediately, suppressing any pending rise
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_div_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else if (w_toggle) begin
          w_div_nxt = '0;
          if (!r_clk_gen) begin
            w_clk_nxt    = 1'b1;
            w_rise_nxt   = 1'b1;
            w_cycles_nxt = r_cycles + C_CNT_ONE;
          end else begin
            w_clk_nxt = 1'b0;
            if (r_stop_pend || stop_i || w_burst_end) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_pend_nxt  = 1'b0;
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + C_DIV_ONE;
          if (r_clk_gen && stop_i) begin
            w_pend_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clk_gen   <= 1'b0;
      r_rise      <= 1'b0;
      r_dut_rst   <= 1'b1;
      r_done      <= 1'b0;
      r_cycles    <= '0;
      r_rst_cnt   <= '0;
      r_div_cnt   <= '0;
      r_burst_len <= '0;
      r_hp        <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_gen   <= w_clk_nxt;
      r_rise      <= w_rise_nxt;
      r_dut_rst   <= w_dut_rst_nxt;
      r_done      <= w_done_nxt;
      r_cycles    <= w_cycles_nxt;
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_div_cnt   <= w_div_nxt;
      r_burst_len <= w_burst_nxt;
      r_hp        <= w_hp_nxt;
      r_stop_pend <= w_pend_nxt;
    end
  end

  assign clk_gen_o = r_clk_gen;
  assign rise_o    = r_rise;
  assign dut_rst_o = r_dut_rst;
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = r_done;
  assign cycles_o  = r_cycles;

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Directed bench for clk_burst_ctrl: burst, free-run stop, invalid start,
// stop during reset, hp=1 burst and mid-run reset.
module tb_clk_burst_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        stop_i;
  logic [15:0] burst_len_i;
  logic [7:0]  half_period_i;
  logic        clk_gen_o;
  logic        rise_o;
  logic        dut_rst_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] cycles_o;

  int n_chk = 0;
  int n_err = 0;

  clk_burst_ctrl #(
    .G_CNT_WIDTH (16),
    .G_DIV_WIDTH (8),
    .G_RST_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .burst_len_i  (burst_len_i),
    .half_period_i(half_period_i),
    .clk_gen_o    (clk_gen_o),
    .rise_o       (rise_o),
    .dut_rst_o    (dut_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cycles_o     (cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start at edge 0, hp=3, burst=2: rises at 7/13, falls at 10/16
  task automatic run_burst_case(input string pfx);
    burst_len_i   = 16'd2;
    half_period_i = 8'd3;
    start_i       = 1'b1;
    step();
    start_i = 1'b0;
    chk({pfx, "_busy0"}, 32'(busy_o), 32'd1);
    chk({pfx, "_cyc0"}, 32'(cycles_o), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("%s_clk_e%0d", pfx, k), 32'(clk_gen_o),
          32'((k >= 7 && k < 10) || (k >= 13 && k < 16)));
      chk($sformatf("%s_rise_e%0d", pfx, k), 32'(rise_o),
          32'(k == 7 || k == 13));
      chk($sformatf("%s_drst_e%0d", pfx, k), 32'(dut_rst_o),
          32'(k < 4));
      chk($sformatf("%s_busy_e%0d", pfx, k), 32'(busy_o), 32'(k < 16));
      chk($sformatf("%s_done_e%0d", pfx, k), 32'(done_o), 32'(k == 16));
    end
    chk({pfx, "_cycles"}, 32'(cycles_o), 32'd2);
    step();
    chk({pfx, "_done_clr"}, 32'(done_o), 32'd0);
    chk({pfx, "_drst_low"}, 32'(dut_rst_o), 32'd0);
    chk({pfx, "_idle_clk"}, 32'(clk_gen_o), 32'd0);
  endtask

  initial begin
    logic got;
    rst           = 1'b1;
    start_i       = 1'b0;
    stop_i        = 1'b0;
    burst_len_i   = '0;
    half_period_i = '0;
    step();
    step();
    chk("rst_clk", 32'(clk_gen_o), 32'd0);
    chk("rst_rise", 32'(rise_o), 32'd0);
    chk("rst_drst", 32'(dut_rst_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cyc", 32'(cycles_o), 32'd0);
    rst = 1'b0;
    step();

    // invalid start with half period 0
    burst_len_i   = 16'd5;
    half_period_i = 8'd0;
    start_i       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t3_busy_%0d", k), 32'(busy_o), 32'd0);
      chk($sformatf("t3_drst_%0d", k), 32'(dut_rst_o), 32'd1);
      chk($sformatf("t3_done_%0d", k), 32'(done_o), 32'd0);
    end
    start_i = 1'b0;

    // stop while in RESET
    half_period_i = 8'd2;
    start_i       = 1'b1;
    step();
    start_i = 1'b0;
    chk("t5_busy", 32'(busy_o), 32'd1);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("t5_busy_off", 32'(busy_o), 32'd0);
    chk("t5_done", 32'(done_o), 32'd1);
    chk("t5_drst", 32'(dut_rst_o), 32'd1);
    chk("t5_clk", 32'(clk_gen_o), 32'd0);
    chk("t5_rise", 32'(rise_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t5_norise_%0d", k), 32'(rise_o), 32'd0);
      chk($sformatf("t5_nodone_%0d", k), 32'(done_o), 32'd0);
    end

    run_burst_case("t1");

    // hp=1 burst=3: toggles every cycle after RUN entry at edge 4
    burst_len_i   = 16'd3;
    half_period_i = 8'd1;
    start_i       = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t4_clk_e%0d", k), 32'(clk_gen_o),
          32'(k >= 5 && k < 10 && (k % 2 == 1)));
      chk($sformatf("t4_rise_e%0d", k), 32'(rise_o),
          32'(k >= 5 && (k % 2 == 1)));
      chk($sformatf("t4_done_e%0d", k), 32'(done_o), 32'(k == 10));
      chk($sformatf("t4_busy_e%0d", k), 32'(busy_o), 32'(k < 10));
    end
    chk("t4_cycles", 32'(cycles_o), 32'd3);

    // free-run hp=5, stop two cycles into the high phase
    burst_len_i   = 16'd0;
    half_period_i = 8'd5;
    start_i       = 1'b1;
    step();
    start_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (rise_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("t2_rise_seen", 32'(got), 32'd1);
    step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("t2_hi_%0d", k), 32'(clk_gen_o), 32'd1);
      chk($sformatf("t2_nodone_%0d", k), 32'(done_o), 32'd0);
      step();
    end
    chk("t2_fall", 32'(clk_gen_o), 32'd0);
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_busy", 32'(busy_o), 32'd0);
    chk("t2_cycles", 32'(cycles_o), 32'd1);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("t2_norise_%0d", k), 32'(rise_o), 32'd0);
      chk($sformatf("t2_low_%0d", k), 32'(clk_gen_o), 32'd0);
    end

    // synchronous reset while the generated clock is high
    burst_len_i   = 16'd0;
    half_period_i = 8'd3;
    start_i       = 1'b1;
    step();
    start_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (clk_gen_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6_high_seen", 32'(got), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_clk", 32'(clk_gen_o), 32'd0);
    chk("t6_rise", 32'(rise_o), 32'd0);
    chk("t6_drst", 32'(dut_rst_o), 32'd1);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_done", 32'(done_o), 32'd0);
    chk("t6_cyc", 32'(cycles_o), 32'd0);
    step();
    run_burst_case("t6b");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
